// File: rtl/imm_decode_stage.sv
// Decode-path immediate generator: classifies the opcode, sign-extends the immediate
// to XLEN and registers the result behind a valid/ready stage with a one-entry skid.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_R   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ent_t;

  fmt_e               fmt_c;
  logic [31:0]        imm32_c;
  logic signed [31:0] imm32_s;
  ent_t               new_ent;

  ent_t               out_q, out_d, skid_q, skid_d;
  logic               out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_xfer, out_xfer;

  always_comb begin
    fmt_c = FMT_ILL;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: fmt_c = FMT_I;
      7'b0100011:             fmt_c = FMT_S;
      7'b1100011:             fmt_c = FMT_B;
      7'b1101111:             fmt_c = FMT_J;
      7'b0110111, 7'b0010111: fmt_c = FMT_U;
      7'b0110011:             fmt_c = FMT_R;
      7'b0011011:             fmt_c = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0111011:             fmt_c = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                fmt_c = FMT_ILL;
    endcase
  end

  // Every format's immediate MSB is instr[31], so a 32-bit form sign-extends uniformly.
  always_comb begin
    imm32_c = '0;
    case (fmt_c)
      FMT_I:   imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_J:   imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      FMT_U:   imm32_c = {in_instr[31:12], 12'b0};
      default: imm32_c = '0;
    endcase
  end

  assign imm32_s = imm32_c;

  always_comb begin
    new_ent       = '0;
    new_ent.imm   = XLEN'(imm32_s);
    new_ent.fmt   = fmt_c;
    new_ent.instr = in_instr;
    new_ent.pc    = in_pc;
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign in_ready = !skid_vld_q && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (!out_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
        if (in_xfer) begin
          skid_d     = new_ent;
          skid_vld_d = 1'b1;
        end
      end else if (in_xfer) begin
        out_d     = new_ent;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = new_ent;
      skid_vld_d = 1'b1;
    end
    if (out_xfer && out_q.fmt == FMT_ILL && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign illegal_cnt = cnt_q;

endmodule
